// File: rtl/loop_sequencer_pkg.sv
// loop_sequencer_pkg
// Shared definitions for the loop sequencer address walker.
//   WORD_SIZE_DEFAULT : default width of addresses and iteration lengths
//   seq_state_t       : 2-bit FSM encoding (IDLE, RUN, DONE)
package loop_sequencer_pkg;

   localparam int WORD_SIZE_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage : loop_sequencer_pkg

// File: rtl/loop_sequencer_step_counter.sv
// step_counter
// Loadable synchronous counter with asynchronous active-high reset.
//   clk, rst      : clock, async active-high reset (value clears to 0)
//   load          : load load_value on the next edge (wins over count_enable)
//   count_enable  : step by one on the next edge (+1 when UP=1, -1 when UP=0)
//   load_value    : value taken on load
//   value         : current count; wraps modulo 2^WIDTH in either direction
module step_counter #(
   parameter int WIDTH = 32,
   parameter bit UP    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             count_enable,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (count_enable) begin
         value <= UP ? (value + ONE) : (value - ONE);
      end
   end

endmodule : step_counter

// File: rtl/loop_sequencer.sv
// loop_sequencer
// Emits an incrementing address stream of `length` addresses starting at
// `start_addr`, then pulses `done` for one cycle.
//   clk, rst     : clock, async active-high reset
//   start        : begin a walk (only looked at in IDLE)
//   start_addr   : first address of the walk
//   length       : number of addresses to emit (0 goes straight to DONE)
//   abort        : cancel the walk (only looked at in RUN), no done pulse
//   step_ready   : consumer accepts the current address
//   busy         : high in RUN and DONE
//   addr_valid   : high in RUN
//   addr         : current address (address counter)
//   last         : current address is the final one, qualified by addr_valid
//   done         : one-cycle pulse after the final transfer
//   fsm_state    : current FSM state, for observation
//
// Handshake: a transfer happens on a rising edge where addr_valid and
// step_ready are both high. While addr_valid is high and no transfer occurs,
// addr and last hold. addr_valid/addr/last come from registered state only,
// never combinationally from step_ready or start.
module loop_sequencer
   import loop_sequencer_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WORD_SIZE-1:0] start_addr,
   input  logic [WORD_SIZE-1:0] length,
   input  logic                 abort,
   input  logic                 step_ready,
   output logic                 busy,
   output logic                 addr_valid,
   output logic [WORD_SIZE-1:0] addr,
   output logic                 last,
   output logic                 done,
   output seq_state_t           fsm_state
);

   localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

   seq_state_t           state;
   seq_state_t           state_next;
   logic                 cnt_load;
   logic                 cnt_step;
   logic                 transfer;
   logic [WORD_SIZE-1:0] remaining;

   // Counters are loaded in IDLE and stepped only on a non-final, non-aborted
   // transfer, so the final address stays on addr after the walk ends.
   step_counter #(.WIDTH(WORD_SIZE), .UP(1'b1)) u_addr_cnt (
      .clk          (clk),
      .rst          (rst),
      .load         (cnt_load),
      .count_enable (cnt_step),
      .load_value   (start_addr),
      .value        (addr)
   );

   // Holds the number of addresses still to come after the current one, so
   // zero marks the final address; length-1 keeps 2^W-1 representable.
   step_counter #(.WIDTH(WORD_SIZE), .UP(1'b0)) u_rem_cnt (
      .clk          (clk),
      .rst          (rst),
      .load         (cnt_load),
      .count_enable (cnt_step),
      .load_value   (length - ONE),
      .value        (remaining)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   assign addr_valid = (state == RUN);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign last       = addr_valid && (remaining == '0);
   assign transfer   = addr_valid && step_ready;
   assign fsm_state  = state;

   always_comb begin
      state_next = state;
      cnt_load   = 1'b0;
      cnt_step   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  cnt_load   = 1'b1;
                  state_next = RUN;
               end else begin
                  state_next = DONE;
               end
            end
         end
         RUN: begin
            // abort wins: a coincident transfer is not counted
            if (abort) begin
               state_next = IDLE;
            end else if (transfer) begin
               if (last) begin
                  state_next = DONE;
               end else begin
                  cnt_step = 1'b1;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule : loop_sequencer

// File: doc/loop_sequencer.md
# loop_sequencer

Address-stream generator that drives an iterated memory or datapath walk in the ODE accelerator. On a start request it loads a base address and an iteration length, then emits one address per accepted step, incrementing from the base, and raises a one-cycle done pulse after the final step. It sits directly upstream of the address/step consumers (state-vector memories, coefficient ROMs). It owns the load/count-enable sequencing of a loadable counter so that downstream stages only see a valid/ready address stream.

## Interface
- WORD_SIZE, 32, width of addresses and of the iteration length
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new walk; sampled only in IDLE
- start_addr  input  WORD_SIZE  first address of the walk
- length  input  WORD_SIZE  number of addresses to emit; 0 is legal
- abort  input  1  cancel the walk in progress
- step_ready  input  1  consumer accepts the current address
- busy  output  1  high in RUN and DONE
- addr_valid  output  1  addr is valid; high only in RUN
- addr  output  WORD_SIZE  current address
- last  output  1  current address is the final one; qualified by addr_valid
- done  output  1  one-cycle pulse after the final transfer

## Operation
- Reset value of every output is 0. The FSM resets to IDLE, and the address counter and remaining counter reset to 0.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and length≠0: load the address counter with start_addr and the remaining counter with length−1, then go to RUN.
  - start=1 and length=0: go to DONE directly. No address is emitted.
  - start=0: stay in IDLE.
- RUN:
  - addr_valid=1, addr=address counter.
  - last=1 when remaining counter = 0.
  - A transfer occurs when addr_valid and step_ready are both high.
  - Transfer with last=0: address counter +1, remaining counter −1, stay in RUN.
  - Transfer with last=1: go to DONE. Counters hold.
  - No transfer: all state holds, and addr stays stable.
  - abort=1: go to IDLE, with no done pulse. abort has priority over a simultaneous transfer; that transfer is still seen by the consumer but is not counted.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE. abort is ignored outside RUN.
- Address arithmetic is modulo 2^WORD_SIZE. The address wraps from all-ones to 0 without any flag.
- The remaining counter is WORD_SIZE wide. length=2^WORD_SIZE−1 is legal and produces that many addresses.
- Asserting rst in any state returns the block to IDLE immediately, with all outputs 0. No done pulse is issued for an interrupted walk.

## Timing
- start accepted at edge t: addr_valid=1 and addr=start_addr are visible after edge t, so the first address is available in the next cycle.
- Throughput is one address per cycle while step_ready is held high.
- Final transfer at edge t: done=1 after edge t for one cycle. busy falls after edge t+1.
- A new start is accepted in the cycle after done, giving a 2-cycle minimum gap between the last address of one walk and the first address of the next.
- For length=0, start at edge t gives done after edge t, and busy is high for that one cycle only.
- addr, last and addr_valid are registered or derived from registered state only. None of them depends combinationally on step_ready or start.

## Structure
- The shared package holds:
  - the state encoding constants IDLE, RUN, DONE (2 bits);
  - the WORD_SIZE default.
- One sub-module is natural: step_counter, a WORD_SIZE-bit loadable synchronous counter with load and count_enable inputs and async active-high reset. It is instantiated twice:
  - as the address counter (up-counting);
  - as the remaining counter (down-counting, via a direction parameter).
- The FSM and the transfer/last logic live in loop_sequencer.

## Test plan
- Reset mid-RUN, then start_addr=0x10, length=4, step_ready=1 constant: addr 0x10,0x11,0x12,0x13 on consecutive cycles; last only on 0x13; done one cycle later; busy low after that.
- Same walk with step_ready toggling 1,0,0,1,1,0,1: addr holds during stalls; exactly 4 transfers; done only after the 4th.
- length=0, start_addr=0x55: addr_valid never rises; done pulses one cycle after start.
- start_addr=0xFFFFFFFE, length=3: addrs 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; last on 0x0; done follows.
- abort asserted on the 2nd address with step_ready=1: next cycle state is IDLE, addr_valid=0, no done; a new start in that cycle is accepted normally.
- start pulsed during RUN with different operands: ignored, and the walk finishes with the original addresses; rst asserted mid-walk forces all outputs to 0 asynchronously.
